// File: rtl/logic_unit_acc_if.sv
// Handshake and data bundle for the streaming logic unit: input beat channel,
// result channel and registered result flags.
interface logic_unit_acc_if #(
   parameter int LENGTH = 32,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [LENGTH-1:0] X;
   logic [LENGTH-1:0] Y;
   logic [1:0]        op;
   logic              accum;
   logic              last;
   logic              out_valid;
   logic              out_ready;
   logic [LENGTH-1:0] Z;
   logic              zero;
   logic              ones;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, X, Y, op, accum, last, out_ready,
      input  in_ready, out_valid, Z, zero, ones, count
   );

   modport slave (
      input  in_valid, X, Y, op, accum, last, out_ready,
      output in_ready, out_valid, Z, zero, ones, count
   );
endinterface

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit (AND/OR/XOR/NOR) with optional multi-beat
// accumulation, valid/ready on both sides and registered zero/ones flags.
module logic_unit_acc #(
   parameter int LENGTH = 32,
   parameter int CNT_W  = 8
) (
   input logic             clk,
   input logic             rst,
   logic_unit_acc_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
   localparam logic [LENGTH-1:0] ALL_ZERO = {LENGTH{1'b0}};

   function automatic logic [LENGTH-1:0] logic_op(input logic [1:0]        sel,
                                                  input logic [LENGTH-1:0] a,
                                                  input logic [LENGTH-1:0] b);
      case (sel)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         2'b11:   return ~(a | b);
         default: return ALL_ZERO;
      endcase
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [LENGTH-1:0] acc_r;
   logic [1:0]        op_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [LENGTH-1:0] z_r;
   logic              zero_r;
   logic              ones_r;
   logic              out_valid_r;
   logic [CNT_W-1:0]  count_r;

   logic              in_ready_s;
   logic              beat_s;
   logic              drain_s;
   logic [LENGTH-1:0] op_res_s;
   logic [LENGTH-1:0] fold_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              load_res_s;
   logic [LENGTH-1:0] res_s;
   logic [CNT_W-1:0]  res_cnt_s;
   logic              start_acc_s;
   logic              step_acc_s;

   // Stalling input only while a result is stuck keeps beats from being lost.
   assign in_ready_s = !out_valid_r | bus.out_ready;
   assign beat_s     = bus.in_valid & in_ready_s;
   assign drain_s    = out_valid_r & bus.out_ready;
   assign op_res_s   = logic_op(bus.op, bus.X, bus.Y);
   assign fold_s     = logic_op(op_r, acc_r, bus.X);
   assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.Z         = z_r;
   assign bus.zero      = zero_r;
   assign bus.ones      = ones_r;
   assign bus.count     = count_r;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt_s = state_r;
      load_res_s  = 1'b0;
      res_s       = ALL_ZERO;
      res_cnt_s   = {CNT_W{1'b0}};
      start_acc_s = 1'b0;
      step_acc_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (beat_s) begin
               if (bus.accum & !bus.last) begin
                  start_acc_s = 1'b1;
                  state_nxt_s = ACC;
               end else begin
                  load_res_s = 1'b1;
                  res_s      = op_res_s;
                  res_cnt_s  = CNT_ONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC: begin
            if (beat_s) begin
               if (bus.last) begin
                  load_res_s  = 1'b1;
                  res_s       = fold_s;
                  res_cnt_s   = cnt_inc_s;
                  state_nxt_s = IDLE;
               end else begin
                  step_acc_s = 1'b1;
               end
            end else begin
               state_nxt_s = ACC;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Result register; flags derive from the value being written, not from Z.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_r         <= ALL_ZERO;
         zero_r      <= 1'b0;
         ones_r      <= 1'b0;
         count_r     <= {CNT_W{1'b0}};
         out_valid_r <= 1'b0;
      end else if (load_res_s) begin
         z_r         <= res_s;
         zero_r      <= (res_s == ALL_ZERO);
         ones_r      <= &res_s;
         count_r     <= res_cnt_s;
         out_valid_r <= 1'b1;
      end else if (drain_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Accumulator, latched op and running beat count.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= ALL_ZERO;
         op_r  <= 2'b00;
         cnt_r <= {CNT_W{1'b0}};
      end else if (start_acc_s) begin
         acc_r <= op_res_s;
         op_r  <= bus.op;
         cnt_r <= CNT_ONE;
      end else if (step_acc_s) begin
         acc_r <= fold_s;
         cnt_r <= cnt_inc_s;
      end else begin
         acc_r <= acc_r;
      end
   end
endmodule

// File: tb/tb_logic_unit_acc.sv
// Bench for logic_unit_acc: directed scenarios plus random traffic against a
// sequence-level reference model (32-bit/8-bit count) and a 1-bit/2-bit-count instance.
module tb_logic_unit_acc;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic_unit_acc_if #(.LENGTH(32), .CNT_W(8)) ba ();
   logic_unit_acc_if #(.LENGTH(1),  .CNT_W(2)) bb ();

   logic_unit_acc #(.LENGTH(32), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ba));
   logic_unit_acc #(.LENGTH(1),  .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending result plus the beats of an open sequence.
   logic        m_ov;
   logic [31:0] m_z;
   logic        m_zero;
   logic        m_ones;
   int          m_cnt;
   bit          m_inseq;
   logic [1:0]  m_op;
   logic [31:0] m_first;
   logic [31:0] m_xs[$];

   logic [31:0] exp_tab[4] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'h000F_000F};

   function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ov = 1'b0; m_z = 32'd0; m_zero = 1'b0; m_ones = 1'b0; m_cnt = 0;
      m_inseq = 1'b0; m_op = 2'd0; m_first = 32'd0; m_xs.delete();
   endtask

   // One clock of dut_a: predict handshake, advance, compare every output.
   task automatic cycle_a();
      logic        exp_rdy, acc, drain, prod, r;
      logic [31:0] res, v;
      int          rc;
      #1;
      r       = rst;
      exp_rdy = !m_ov || ba.out_ready;
      chk("in_ready", 64'(ba.in_ready), 64'(exp_rdy));
      acc   = ba.in_valid && exp_rdy && !r;
      drain = m_ov && ba.out_ready;
      prod  = 1'b0; res = 32'd0; rc = 0;
      if (acc) begin
         if (!m_inseq) begin
            if (ba.accum && !ba.last) begin
               m_inseq = 1'b1; m_op = ba.op; m_first = ref_op(ba.op, ba.X, ba.Y); m_xs.delete();
            end else begin
               prod = 1'b1; res = ref_op(ba.op, ba.X, ba.Y); rc = 1;
            end
         end else begin
            m_xs.push_back(ba.X);
            if (ba.last) begin
               v = m_first;
               foreach (m_xs[i]) v = ref_op(m_op, v, m_xs[i]);
               prod = 1'b1; res = v;
               rc = 1 + m_xs.size();
               if (rc > 255) rc = 255;
               m_inseq = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      if (r) model_reset();
      else if (prod) begin
         m_ov = 1'b1; m_z = res; m_zero = (res == 32'd0); m_ones = &res; m_cnt = rc;
      end else if (drain) m_ov = 1'b0;
      chk("out_valid", 64'(ba.out_valid), 64'(m_ov));
      chk("Z",         64'(ba.Z),         64'(m_z));
      chk("zero",      64'(ba.zero),      64'(m_zero));
      chk("ones",      64'(ba.ones),      64'(m_ones));
      chk("count",     64'(ba.count),     64'(m_cnt));
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      model_reset();
      rst = 1'b1;
      ba.in_valid = 1'b0; ba.X = 32'd0; ba.Y = 32'd0; ba.op = 2'd0;
      ba.accum = 1'b0; ba.last = 1'b0; ba.out_ready = 1'b1;
      bb.in_valid = 1'b0; bb.X = 1'b0; bb.Y = 1'b0; bb.op = 2'd0;
      bb.accum = 1'b0; bb.last = 1'b0; bb.out_ready = 1'b1;
      cycle_a();
      cycle_a();
      rst = 1'b0;
      chk("rst_ready_b", 64'(bb.in_ready), 64'd1);
      chk("rst_count_b", 64'(bb.count), 64'd0);

      // 1-bit instance: flags complementary, then count saturation at 3.
      bb.in_valid = 1'b1; bb.X = 1'b1; bb.Y = 1'b0; bb.op = 2'd2;
      @(posedge clk); #1;
      chk("b_single_z",    64'(bb.Z), 64'd1);
      chk("b_single_ones", 64'(bb.ones), 64'd1);
      chk("b_single_zero", 64'(bb.zero), 64'd0);
      chk("b_single_cnt",  64'(bb.count), 64'd1);
      bb.X = 1'b0; bb.Y = 1'b0; bb.op = 2'd1; bb.accum = 1'b1;
      @(posedge clk); #1;
      chk("b_acc_drained", 64'(bb.out_valid), 64'd0);
      bb.accum = 1'b0;
      for (int b = 2; b <= 6; b++) begin
         bb.last = (b == 6);
         @(posedge clk); #1;
      end
      bb.in_valid = 1'b0; bb.last = 1'b0;
      chk("b_sat_valid", 64'(bb.out_valid), 64'd1);
      chk("b_sat_count", 64'(bb.count), 64'd3);
      chk("b_sat_zero",  64'(bb.zero), 64'd1);
      chk("b_sat_ones",  64'(bb.ones), 64'd0);
      cycle_a();

      // Single operations, back to back.
      ba.in_valid = 1'b1; ba.X = 32'hF0F0_F0F0; ba.Y = 32'h0FF0_0FF0; ba.accum = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ba.op = 2'(k);
         cycle_a();
         chk("single_z", 64'(ba.Z), 64'(exp_tab[k]));
         chk("single_cnt", 64'(ba.count), 64'd1);
      end

      // OR accumulate over three beats.
      ba.op = 2'd1; ba.accum = 1'b1; ba.X = 32'd1; ba.Y = 32'd2;
      cycle_a();
      chk("or_acc_pending", 64'(ba.out_valid), 64'd0);
      ba.accum = 1'b0; ba.X = 32'd4;
      cycle_a();
      chk("or_acc_pending2", 64'(ba.out_valid), 64'd0);
      ba.X = 32'd8; ba.last = 1'b1;
      cycle_a();
      chk("or_acc_z", 64'(ba.Z), 64'h0000_000F);
      chk("or_acc_cnt", 64'(ba.count), 64'd3);

      // Op latched on the first beat.
      ba.op = 2'd2; ba.accum = 1'b1; ba.last = 1'b0; ba.X = 32'hFFFF_FFFF; ba.Y = 32'd0;
      cycle_a();
      ba.op = 2'd0; ba.accum = 1'b0; ba.last = 1'b1;
      cycle_a();
      chk("xor_latch_z", 64'(ba.Z), 64'd0);
      chk("xor_latch_zero", 64'(ba.zero), 64'd1);
      chk("xor_latch_cnt", 64'(ba.count), 64'd2);

      // Back-pressure then simultaneous drain and load.
      ba.last = 1'b0; ba.op = 2'd1; ba.X = 32'h12; ba.Y = 32'h30;
      cycle_a();
      ba.out_ready = 1'b0; ba.op = 2'd0; ba.X = 32'h55;
      for (int k = 0; k < 5; k++) begin
         cycle_a();
         chk("bp_hold_z", 64'(ba.Z), 64'h32);
      end
      ba.out_ready = 1'b1;
      cycle_a();
      chk("bp_reload_valid", 64'(ba.out_valid), 64'd1);
      chk("bp_reload_z", 64'(ba.Z), 64'h10);

      // Reset in the middle of an accumulate sequence.
      ba.op = 2'd1; ba.accum = 1'b1; ba.X = 32'd3;
      cycle_a();
      ba.accum = 1'b0; ba.X = 32'd5;
      cycle_a();
      ba.in_valid = 1'b0; rst = 1'b1;
      cycle_a();
      rst = 1'b0;
      chk("midrst_valid", 64'(ba.out_valid), 64'd0);
      chk("midrst_cnt", 64'(ba.count), 64'd0);
      ba.in_valid = 1'b1; ba.op = 2'd0; ba.X = 32'hFFFF_FFFF; ba.Y = 32'hFFFF_FFFF;
      cycle_a();
      chk("post_rst_z", 64'(ba.Z), 64'hFFFF_FFFF);
      chk("post_rst_ones", 64'(ba.ones), 64'd1);
      chk("post_rst_cnt", 64'(ba.count), 64'd1);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         ba.in_valid  = ($urandom_range(0, 3) != 0);
         ba.out_ready = ($urandom_range(0, 3) != 0);
         ba.X         = $urandom;
         ba.Y         = $urandom;
         ba.op        = 2'($urandom_range(0, 3));
         ba.accum     = ($urandom_range(0, 1) != 0);
         ba.last      = ($urandom_range(0, 3) == 0);
         cycle_a();
      end
      ba.in_valid = 1'b0; ba.out_ready = 1'b1;
      cycle_a();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
